edge_pulse_generator: RTL and testbench
=======================================

Name: edge_pulse_generator

Overview:
- Transmit-side counterpart to the edge detectors: drives a single-bit line with a programmed train of pulses.
- Each pulse is a rising edge, a programmable high time, a falling edge, then a programmable low time.
- The block generates the stimulus waveform that the posedge/negedge detectors consume, so a generator→detector loop can be built on-chip.
- Handshake: single-cycle start, busy level, single-cycle done, abort.

Parameters:
- CNT_W, 8, width of pulse-count request and sent-pulse counter
- TIME_W, 8, width of high/low duration fields (in clk cycles)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- num_pulses  input  CNT_W  pulses to emit; latched on accepted start
- high_time  input  TIME_W  cycles data_out stays 1 per pulse; latched on start; 0 treated as 1
- low_time  input  TIME_W  cycles data_out stays 0 after each fall; latched on start; 0 treated as 1
- abort  input  1  terminate train; highest priority after rst
- data_out  output  1  generated waveform, registered, idles 0
- fall_strobe  output  1  1-cycle pulse in the first cycle data_out is 0 after a 1
- busy  output  1  high from cycle after accepted start until return to IDLE
- done  output  1  1-cycle pulse on normal completion
- pulses_sent  output  CNT_W  count of completed falling edges in current/last train

Behaviour:
- Reset: data_out=0, fall_strobe=0, busy=0, done=0, pulses_sent=0, state=IDLE, internal timers/counters=0.
- FSM states: IDLE, HIGH, LOW, FINISH.
- IDLE → HIGH: start=1 and num_pulses≠0 at edge T.
  - At that edge, latch num_pulses/high_time/low_time (0 durations clamped to 1) and clear pulses_sent.
  - data_out=1 and busy=1 from cycle T+1.
- IDLE, start=1 with num_pulses=0: no pulse, busy stays 0, pulses_sent cleared, done=1 in cycle T+1 only.
- HIGH: data_out=1 for exactly H cycles, then → LOW.
  - First LOW cycle: data_out=0, fall_strobe=1, pulses_sent increments by 1.
- LOW: data_out=0 for exactly L cycles.
  - Then → HIGH if pulses_sent < latched count.
  - Otherwise → FINISH.
- FINISH: one cycle with done=1, busy=1, data_out=0; then → IDLE, busy=0.
- Cycle budget: start to done = N*(H+L)+1 cycles. First rising edge 1 cycle after start.
- Outputs are all registered; no combinational path from inputs to outputs.
- start while busy: ignored; latched parameters are unaffected by input changes mid-train.
- abort=1 in any non-IDLE state: next cycle state=IDLE, data_out=0, busy=0, done=0.
  - fall_strobe=0 even if data_out was 1 (aborted fall is not counted).
  - pulses_sent holds its value.
- abort in IDLE: no effect. If abort and start are both 1 in IDLE, abort wins: start is not accepted and done is not pulsed.
- rst=1 mid-train: full reset values next cycle; overrides abort/start.
- Counters use CNT_W/TIME_W widths. Max count 2^CNT_W−1 must complete without wrap; the comparison is done at full width.
- Timer reload: a down-counter loads H−1 or L−1 on state entry, and the transition occurs when it reaches 0.

Decomposition:
- Shared package edge_pkg:
  - state enum/localparams IDLE=2'd0, HIGH=2'd1, LOW=2'd2, FINISH=2'd3
  - default width constants, plus a clamp-to-1 function for duration fields
- One natural sub-module: dur_timer (loadable down-counter with zero flag), instantiated once and reused for both HIGH and LOW phases.
- Benches instantiate the existing negedge_detector/posedge_detector on data_out as scoreboard monitors.

Test Plan:
- N=3, H=2, L=3, start at T: data_out = 1,1,0,0,0 repeated ×3 from T+1; fall_strobe at T+3, T+8, T+13; done at T+16; pulses_sent=3; negedge detector fires 3 times.
- N=0 start: data_out stays 0, busy never 1, done=1 only at T+1, pulses_sent=0.
- H=0, L=0, N=2: clamped to 1. data_out=1,0,1,0 from T+1; done at T+5.
- Start re-pulsed and num_pulses/high_time changed mid-train (N=2, H=4, L=4): waveform unchanged; exactly 2 falls; done at T+17.
- Abort during second HIGH of N=4, H=3, L=3 train: data_out=0 next cycle, no fall_strobe, no done, busy=0, pulses_sent=1. A new start is accepted on the following cycle.
- rst asserted during LOW phase: all outputs at reset values next cycle. Simultaneous start+rst leaves the block idle.

Source files
------------

// File: rtl/edge_pulse_generator_pkg.sv
`default_nettype none
// Shared state encoding, default widths and duration clamp for the edge pulse generator.
package edge_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int TIME_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    FINISH = 2'd3
  } state_t;

  // A zero duration would never let the down-counter expire on entry, so it means one cycle.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pulse_generator_dur_timer.sv
`default_nettype none
// Loadable down-counter with a zero flag; times both the HIGH and LOW phases.
module dur_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/edge_pulse_generator.sv
`default_nettype none
// Drives a registered single-bit line with a programmed train of high/low pulses,
// with start/busy/done/abort handshake and a count of completed falling edges.
module edge_pulse_generator
  import edge_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_pulses,
  input  logic [TIME_W-1:0] high_time,
  input  logic [TIME_W-1:0] low_time,
  input  logic              abort,
  output logic              data_out,
  output logic              fall_strobe,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pulses_sent
);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt_lat;
  logic [TIME_W-1:0]   high_lat, low_lat;
  logic [TIME_W-1:0]   high_clamped, low_clamped;
  logic                data_n, fall_n, busy_n, done_n, latch;
  logic [CNT_W-1:0]    sent_n;
  logic                tmr_load, tmr_zero;
  logic [TIME_W-1:0]   tmr_val;

  assign high_clamped = TIME_W'(clamp_to_one(32'(high_time)));
  assign low_clamped  = TIME_W'(clamp_to_one(32'(low_time)));

  dur_timer #(.W(TIME_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state logic also computes the next value of every registered output.
  always_comb begin
    state_n  = state;
    data_n   = 1'b0;
    fall_n   = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    sent_n   = pulses_sent;
    tmr_load = 1'b0;
    tmr_val  = '0;
    latch    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          sent_n = '0;
          if (num_pulses != '0) begin
            state_n  = HIGH;
            latch    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = high_clamped - TIME_W'(1);
            data_n   = 1'b1;
            busy_n   = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      HIGH: begin
        busy_n = 1'b1;
        if (tmr_zero) begin
          state_n  = LOW;
          tmr_load = 1'b1;
          tmr_val  = low_lat - TIME_W'(1);
          fall_n   = 1'b1;
          sent_n   = pulses_sent + CNT_W'(1);
        end else begin
          data_n = 1'b1;
        end
      end
      LOW: begin
        busy_n = 1'b1;
        if (tmr_zero) begin
          if (pulses_sent < cnt_lat) begin
            state_n  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = high_lat - TIME_W'(1);
            data_n   = 1'b1;
          end else begin
            state_n = FINISH;
            done_n  = 1'b1;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // An aborted fall is not counted and no strobe or done is produced.
    if (abort && (state != IDLE)) begin
      state_n  = IDLE;
      data_n   = 1'b0;
      fall_n   = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      sent_n   = pulses_sent;
      tmr_load = 1'b0;
      latch    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt_lat     <= '0;
      high_lat    <= '0;
      low_lat     <= '0;
      data_out    <= 1'b0;
      fall_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
    end else begin
      state       <= state_n;
      data_out    <= data_n;
      fall_strobe <= fall_n;
      busy        <= busy_n;
      done        <= done_n;
      pulses_sent <= sent_n;
      if (latch) begin
        cnt_lat  <= num_pulses;
        high_lat <= high_clamped;
        low_lat  <= low_clamped;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_pulse_generator.sv
`default_nettype none
// Bench for edge_pulse_generator: directed and random trains checked cycle by cycle
// against an expected-waveform queue built from the pulse-train rules.
module tb_edge_pulse_generator;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] num_pulses, high_time, low_time;
  logic       data_out, fall_strobe, busy, done;
  logic [7:0] pulses_sent;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic       d;
    logic       f;
    logic       b;
    logic       dn;
    logic [7:0] s;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  always #5 clk = ~clk;

  edge_pulse_generator #(.CNT_W(8), .TIME_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_pulses  (num_pulses),
    .high_time   (high_time),
    .low_time    (low_time),
    .abort       (abort),
    .data_out    (data_out),
    .fall_strobe (fall_strobe),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic exp_t idle_val(input logic [7:0] s, input logic dn);
    exp_t e;
    e.d = 1'b0; e.f = 1'b0; e.b = 1'b0; e.dn = dn; e.s = s;
    return e;
  endfunction

  // Expected waveform for a whole train: N x (H high cycles, L low cycles), then one done cycle.
  task automatic build_train(input int n, input int h, input int l);
    exp_t e;
    int hh, ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    q.delete();
    for (int p = 1; p <= n; p++) begin
      for (int i = 0; i < hh; i++) begin
        e.d = 1'b1; e.f = 1'b0; e.b = 1'b1; e.dn = 1'b0; e.s = 8'(p - 1);
        q.push_back(e);
      end
      for (int i = 0; i < ll; i++) begin
        e.d = 1'b0; e.f = (i == 0); e.b = 1'b1; e.dn = 1'b0; e.s = 8'(p);
        q.push_back(e);
      end
    end
    e.d = 1'b0; e.f = 1'b0; e.b = 1'b1; e.dn = 1'b1; e.s = 8'(n);
    q.push_back(e);
  endtask

  task automatic model_step(input logic st, input logic [7:0] n, input logic [7:0] h,
                            input logic [7:0] l, input logic ab, input logic rs);
    if (rs) begin
      q.delete();
      cur = idle_val(8'd0, 1'b0);
    end else if (cur.b) begin
      if (ab) begin
        q.delete();
        cur = idle_val(cur.s, 1'b0);
      end else if (q.size() != 0) begin
        cur = q.pop_front();
      end else begin
        cur = idle_val(cur.s, 1'b0);
      end
    end else if (st && !ab) begin
      if (n == 8'd0) begin
        cur = idle_val(8'd0, 1'b1);
      end else begin
        build_train(int'(n), int'(h), int'(l));
        cur = q.pop_front();
      end
    end else begin
      cur = idle_val(cur.s, 1'b0);
    end
  endtask

  task automatic cycle(input logic st, input logic [7:0] n, input logic [7:0] h,
                       input logic [7:0] l, input logic ab, input logic rs);
    start = st; num_pulses = n; high_time = h; low_time = l; abort = ab; rst = rs;
    @(posedge clk);
    #1;
    model_step(st, n, h, l, ab, rs);
    chk("data_out",    32'(data_out),    32'(cur.d));
    chk("fall_strobe", 32'(fall_strobe), 32'(cur.f));
    chk("busy",        32'(busy),        32'(cur.b));
    chk("done",        32'(done),        32'(cur.dn));
    chk("pulses_sent", 32'(pulses_sent), 32'(cur.s));
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // Runs until the model returns to idle; inputs scrambled, with optional random abort.
  task automatic run_train(input logic [7:0] n, input logic [7:0] h, input logic [7:0] l,
                           input int abort_pct);
    int guard;
    cycle(1'b1, n, h, l, 1'b0, 1'b0);
    guard = 0;
    while (cur.b && guard < 2000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 99) < abort_pct), 1'b0);
      guard++;
    end
    chk("train_terminates", 32'(guard < 2000), 32'd1);
  endtask

  initial begin
    cur = idle_val(8'd0, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'd3, 8'd2, 8'd3, 1'b1, 1'b1);
    idle_cycles(2);

    run_train(8'd3, 8'd2, 8'd3, 0);
    chk("n3_sent", 32'(pulses_sent), 32'd3);
    idle_cycles(1);

    run_train(8'd0, 8'd5, 8'd5, 0);
    idle_cycles(2);
    chk("n0_sent", 32'(pulses_sent), 32'd0);

    run_train(8'd2, 8'd0, 8'd0, 0);
    idle_cycles(1);
    run_train(8'd2, 8'd4, 8'd4, 0);
    chk("restart_sent", 32'(pulses_sent), 32'd2);

    // Abort during the second HIGH phase, then restart immediately.
    cycle(1'b1, 8'd4, 8'd3, 8'd3, 1'b0, 1'b0);
    idle_cycles(7);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    chk("abort_sent", 32'(pulses_sent), 32'd1);
    run_train(8'd1, 8'd1, 8'd2, 0);

    // Abort and start together in idle: abort wins.
    cycle(1'b1, 8'd2, 8'd2, 8'd2, 1'b1, 1'b0);
    idle_cycles(2);

    // Reset during LOW, then start held with reset.
    cycle(1'b1, 8'd3, 8'd2, 8'd3, 1'b0, 1'b0);
    idle_cycles(3);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'd3, 8'd2, 8'd3, 1'b0, 1'b1);
    idle_cycles(2);
    chk("rst_idle_busy", 32'(busy), 32'd0);

    // Full-width count must complete without wrap.
    run_train(8'd255, 8'd1, 8'd1, 0);
    chk("max_sent", 32'(pulses_sent), 32'd255);
    idle_cycles(1);

    for (int t = 0; t < 30; t++) begin
      run_train(8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                8'($urandom_range(0, 5)), (t % 3 == 0) ? 8 : 0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
